// File: rtl/drive_cmd_uart_tx.sv
// rtl/drive_cmd_uart_tx.sv - 8N1 UART transmitter for driving-command bytes
//
// Accepts one command byte per valid/ready handshake and shifts it out as a
// start bit, eight data bits (LSB first) and a stop bit, each DIV clocks long.
// DIV = CLK_FREQ / BAUD. The transmitter owns the line until the stop bit ends.
//
// Optional feature macro: DRIVE_TX_REPEAT_EN
//   When defined, the last accepted byte is re-sent automatically after
//   REFRESH_CYCLES idle cycles. This only happens once a byte has been
//   accepted since reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_data   command byte from the driving controller
//   cmd_valid  cmd_data is valid this cycle
//   cmd_ready  block can accept a byte this cycle (registered)
//   tx         UART serial line, idle high (registered)
//   busy       a frame is in progress (registered)
//   last_cmd   most recently accepted byte
module drive_cmd_uart_tx #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD           = 9600,
    parameter int REFRESH_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] last_cmd
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    last_next;
    logic          tx_next;
    logic          baud_end;

`ifdef DRIVE_TX_REPEAT_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] refresh_cnt, refresh_next;
    // Set by the first accepted byte; blocks repeats of the reset value.
    logic          have_cmd, have_next;
`endif

    assign baud_end = (baud_cnt == DIV_LAST);

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        last_next  = last_cmd;
        tx_next    = tx;
`ifdef DRIVE_TX_REPEAT_EN
        refresh_next = refresh_cnt;
        have_next    = have_cmd;
`endif
        if (state != IDLE) begin
            baud_next = baud_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    // tx is registered, so the start bit is driven from the
                    // handshake edge itself.
                    shift_next = cmd_data;
                    last_next  = cmd_data;
                    state_next = START;
                    baud_next  = '0;
                    tx_next    = 1'b0;
`ifdef DRIVE_TX_REPEAT_EN
                    refresh_next = '0;
                    have_next    = 1'b1;
`endif
                end
`ifdef DRIVE_TX_REPEAT_EN
                else if (have_cmd && refresh_cnt == REFRESH_LAST) begin
                    shift_next   = last_cmd;
                    state_next   = START;
                    baud_next    = '0;
                    tx_next      = 1'b0;
                    refresh_next = '0;
                end else if (refresh_cnt != REFRESH_LAST) begin
                    refresh_next = refresh_cnt + 1'b1;
                end
`endif
            end
            START: begin
                if (baud_end) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        // Next bit goes out the same edge the register shifts.
                        shift_next = {1'b0, shift[7:1]};
                        tx_next    = shift[1];
                        bit_next   = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
`ifdef DRIVE_TX_REPEAT_EN
                    refresh_next = '0;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            last_cmd  <= 8'h00;
            tx        <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
`ifdef DRIVE_TX_REPEAT_EN
            refresh_cnt <= '0;
            have_cmd    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift     <= shift_next;
            last_cmd  <= last_next;
            tx        <= tx_next;
            cmd_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
`ifdef DRIVE_TX_REPEAT_EN
            refresh_cnt <= refresh_next;
            have_cmd    <= have_next;
`endif
        end
    end

endmodule

// File: tb/tb_drive_cmd_uart_tx.sv
// tb/tb_drive_cmd_uart_tx.sv - directed self-checking bench for drive_cmd_uart_tx
module tb_drive_cmd_uart_tx;

    localparam int NONE = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       tx;
    logic       busy;
    logic [7:0] last_cmd;

    int checks = 0;
    int errors = 0;

    drive_cmd_uart_tx #(
        .CLK_FREQ      (100),
        .BAUD          (10),
        .REFRESH_CYCLES(50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .tx       (tx),
        .busy     (busy),
        .last_cmd (last_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle: present a byte and let one edge take it.
    task automatic handshake(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Samples one 100-cycle frame on negedges. Cycle 0 is the first cycle
    // after the handshake edge; 'first' cycles are assumed already consumed.
    // At cycle pulse_at a one-cycle cmd_valid with 0x3C is injected.
    task automatic frame_check(input string tag, input logic [7:0] b,
                               input int first, input int pulse_at);
        int   bad = 0;
        int   low = 0;
        logic e;
        for (int i = first; i < 100; i++) begin
            @(negedge clk);
            if (i < 10)       e = 1'b0;
            else if (i >= 90) e = 1'b1;
            else              e = b[(i - 10) / 10];
            if (tx !== e) bad++;
            if (cmd_ready === 1'b0 && busy === 1'b1) low++;
            if (i == pulse_at) begin
                cmd_valid = 1'b1;
                cmd_data  = 8'h3C;
            end else if (i == pulse_at + 1) begin
                cmd_valid = 1'b0;
            end
        end
        chk({tag, "_tx_bad_cycles"}, bad, 0);
        chk({tag, "_busy_cycles"}, low, 100 - first);
    endtask

    initial begin
        int idle;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_last", last_cmd, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte 0xA5
        chk("a_ready_before", cmd_ready, 1);
        handshake(8'hA5);
        cmd_data = 8'hFF;
        frame_check("a", 8'hA5, 0, NONE);
        @(negedge clk);
        chk("a_ready_after", cmd_ready, 1);
        chk("a_busy_after", busy, 0);
        chk("a_last", last_cmd, 8'hA5);

        // Back-to-back 0x01 then 0x80 with cmd_valid held high
        cmd_data  = 8'h01;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_data = 8'h80;
        frame_check("b1", 8'h01, 0, NONE);
        @(negedge clk);
        chk("b_gap_ready", cmd_ready, 1);
        chk("b_gap_tx", tx, 1);
        chk("b_last1", last_cmd, 8'h01);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        frame_check("b2", 8'h80, 0, NONE);
        @(negedge clk);
        chk("b_last2", last_cmd, 8'h80);

        // cmd_valid while busy is dropped
        handshake(8'h55);
        frame_check("c", 8'h55, 0, 40);
        @(negedge clk);
        chk("c_last", last_cmd, 8'h55);
        chk("c_ready_after", cmd_ready, 1);
        idle = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx === 1'b1 && cmd_ready === 1'b1) idle++;
        end
        chk("c_no_3c_frame", idle, 20);

        // Idle behaviour after a frame
        handshake(8'h12);
        frame_check("d", 8'h12, 0, NONE);
`ifdef DRIVE_TX_REPEAT_EN
        idle = 0;
        while (idle < 200) begin
            @(negedge clk);
            if (tx !== 1'b1) break;
            idle++;
        end
        chk("d_repeat_delay", idle, 50);
        chk("d_repeat_ready", cmd_ready, 0);
        frame_check("d_rep", 8'h12, 1, NONE);
        chk("d_rep_last", last_cmd, 8'h12);

        // New byte in the refresh-expiry cycle wins
        repeat (50) @(negedge clk);
        chk("e_ready", cmd_ready, 1);
        handshake(8'h34);
        frame_check("e", 8'h34, 0, NONE);
        @(negedge clk);
        chk("e_last", last_cmd, 8'h34);
`else
        idle = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (tx === 1'b1 && cmd_ready === 1'b1) idle++;
        end
        chk("d_quiet_500", idle, 500);
`endif

        // Asynchronous reset mid-DATA of a 0xFF frame
        @(negedge clk);
        handshake(8'hFF);
        repeat (35) @(negedge clk);
        chk("f_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("f_rst_tx", tx, 1);
        chk("f_rst_ready", cmd_ready, 1);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_last", last_cmd, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        idle = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx === 1'b1 && cmd_ready === 1'b1) idle++;
        end
        chk("f_no_resume", idle, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
